// File: rtl/ela_deinterlace_engine.sv
// ---------------------------------------------------------------------------
// ela_deinterlace_engine
//
// Purpose: memory-to-memory deinterlacer. After a power-up settle time the
// whole source image is copied to the destination. Then every odd row that
// has a row below it is rebuilt from its neighbours. The reconstruction uses
// one of three methods: edge-based line averaging (ELA), line doubling, or
// vertical averaging. The engine then idles in DONE until cmd changes.
//
// Ports:
//   clk_p        in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   cmd[1:0]     in   00 ELA, 01 copy only, 10 line-double, 11 vertical avg
//   r_addr       out  source read address (data_in follows one cycle later)
//   data_in      in   source pixel, NUM_CH channels of CH_WIDTH bits
//   o_addr       out  destination write address
//   data_out     out  destination write data
//   output_valid out  write strobe; one write per high cycle
//   all_ready    out  high while the current pass is complete
//   dbg_state_o  out  current FSM state (state_t encoding)
//
// Handshake: output_valid is a push-only strobe with no ready. The
// destination accepts data_out at o_addr on every cycle output_valid is high.
// The source returns data_in exactly one cycle after r_addr is presented.
// ---------------------------------------------------------------------------
module ela_deinterlace_engine #(
    parameter int CH_WIDTH    = 4,
    parameter int NUM_CH      = 3,
    parameter int IMG_W       = 400,
    parameter int IMG_H       = 300,
    parameter int ADDR_WIDTH  = 19,
    parameter int WAIT_CYCLES = 1024,
    localparam int DATA_WIDTH = CH_WIDTH * NUM_CH
) (
    input  logic                  clk_p,
    input  logic                  rst,
    input  logic [1:0]            cmd,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_valid,
    output logic                  all_ready,
    output logic [2:0]            dbg_state_o
);

    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WCW  = $clog2(WAIT_CYCLES + 1);
    localparam int NPIX = IMG_W * IMG_H;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    localparam logic [XW-1:0]         X_LAST    = XW'(IMG_W - 1);
    // Highest odd row that still has a row below it.
    localparam logic [YW-1:0]         Y_LAST    =
        YW'((((IMG_H - 2) % 2) == 1) ? (IMG_H - 2) : (IMG_H - 3));

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_COPY  = 3'd1,
        S_CHECK = 3'd2,
        S_FETCH = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // How the current pixel is rebuilt (number of reads differs per kind).
    typedef enum logic [1:0] {
        K_ELA = 2'd0,
        K_AVG = 2'd1,
        K_DBL = 2'd2
    } kind_t;

    state_t                  state_q;
    logic [WCW-1:0]          wait_cnt_q;
    logic [1:0]              cmd_q;
    logic [1:0]              mode_q;
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic [ADDR_WIDTH-1:0]   o_addr_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    output_valid_q;
    logic                    all_ready_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic [2:0]              fc_q;
    logic                    rd_pend_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    issue_done_q;
    logic [DATA_WIDTH-1:0]   pix_q [8];

    kind_t                   kind_c;
    logic [2:0]              n_rd;
    logic [ADDR_WIDTH-1:0]   cur_a;
    logic [ADDR_WIDTH-1:0]   up_a;
    logic [ADDR_WIDTH-1:0]   dn_a;
    logic [ADDR_WIDTH-1:0]   rd_a [8];
    logic [DATA_WIDTH-1:0]   pix_c [8];
    logic [DATA_WIDTH-1:0]   res_d;

    // ---------------------------------------------------------------- helpers
    function automatic logic [CH_WIDTH-1:0] avg2(input logic [CH_WIDTH-1:0] p,
                                                  input logic [CH_WIDTH-1:0] q);
        logic [CH_WIDTH:0] s;
        s = {1'b0, p} + {1'b0, q};
        return s[CH_WIDTH:1];
    endfunction

    function automatic logic [CH_WIDTH-1:0] absdiff(input logic [CH_WIDTH-1:0] p,
                                                     input logic [CH_WIDTH-1:0] q);
        return (p > q) ? (p - q) : (q - p);
    endfunction

    // Interpolate along the direction with the smallest difference;
    // the vertical pair wins all ties, then the a/f diagonal.
    function automatic logic [CH_WIDTH-1:0] ela_ch(input logic [CH_WIDTH-1:0] a,
                                                    input logic [CH_WIDTH-1:0] b,
                                                    input logic [CH_WIDTH-1:0] c,
                                                    input logic [CH_WIDTH-1:0] d,
                                                    input logic [CH_WIDTH-1:0] e,
                                                    input logic [CH_WIDTH-1:0] f);
        logic [CH_WIDTH-1:0] d1, d2, d3;
        d1 = absdiff(a, f);
        d2 = absdiff(b, e);
        d3 = absdiff(c, d);
        if (d2 <= d1 && d2 <= d3) return avg2(b, e);
        else if (d1 <= d3)        return avg2(a, f);
        else                      return avg2(c, d);
    endfunction

    // ---------------------------------------------------- address generation
    assign cur_a = ADDR_WIDTH'(y_q) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(x_q);
    assign up_a  = cur_a - ADDR_WIDTH'(IMG_W);
    assign dn_a  = cur_a + ADDR_WIDTH'(IMG_W);

    always_comb begin
        kind_c = K_ELA;
        if (mode_q == 2'b10)                      kind_c = K_DBL;
        else if (mode_q == 2'b11)                 kind_c = K_AVG;
        else if (x_q == '0 || x_q == X_LAST)      kind_c = K_AVG;
    end

    // Read list per kind; slot order matches pix_q: a,b,c,d,e,f for ELA,
    // b,e for averaging and b alone for line doubling.
    always_comb begin
        for (int j = 0; j < 8; j++) rd_a[j] = up_a;
        n_rd = 3'd1;
        case (kind_c)
            K_ELA: begin
                rd_a[0] = up_a - ADDR_WIDTH'(1);
                rd_a[1] = up_a;
                rd_a[2] = up_a + ADDR_WIDTH'(1);
                rd_a[3] = dn_a - ADDR_WIDTH'(1);
                rd_a[4] = dn_a;
                rd_a[5] = dn_a + ADDR_WIDTH'(1);
                n_rd    = 3'd6;
            end
            K_AVG: begin
                rd_a[1] = dn_a;
                n_rd    = 3'd2;
            end
            default: ;
        endcase
    end

    // The final read arrives on the last FETCH cycle; compute straight from
    // data_in for that slot instead of spending a cycle to register it.
    always_comb begin
        for (int j = 0; j < 8; j++) pix_c[j] = pix_q[j];
        if (fc_q != 3'd0) pix_c[fc_q - 3'd1] = data_in;
    end

    always_comb begin
        res_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (kind_c)
                K_ELA: res_d[c*CH_WIDTH +: CH_WIDTH] = ela_ch(
                           pix_c[0][c*CH_WIDTH +: CH_WIDTH], pix_c[1][c*CH_WIDTH +: CH_WIDTH],
                           pix_c[2][c*CH_WIDTH +: CH_WIDTH], pix_c[3][c*CH_WIDTH +: CH_WIDTH],
                           pix_c[4][c*CH_WIDTH +: CH_WIDTH], pix_c[5][c*CH_WIDTH +: CH_WIDTH]);
                K_AVG: res_d[c*CH_WIDTH +: CH_WIDTH] = avg2(
                           pix_c[0][c*CH_WIDTH +: CH_WIDTH], pix_c[1][c*CH_WIDTH +: CH_WIDTH]);
                default: res_d[c*CH_WIDTH +: CH_WIDTH] = pix_c[0][c*CH_WIDTH +: CH_WIDTH];
            endcase
        end
    end

    // Fetched neighbours; pure data, no reset needed.
    always_ff @(posedge clk_p) begin
        if (state_q == S_FETCH && fc_q != 3'd0) pix_q[fc_q - 3'd1] <= data_in;
    end

    // --------------------------------------------------------------- main FSM
    always_ff @(posedge clk_p) begin
        cmd_q <= cmd;
        if (rst) begin
            state_q        <= S_WAIT;
            wait_cnt_q     <= '0;
            mode_q         <= 2'b00;
            r_addr_q       <= '0;
            o_addr_q       <= '0;
            data_out_q     <= '0;
            output_valid_q <= 1'b0;
            all_ready_q    <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            fc_q           <= '0;
            rd_pend_q      <= 1'b0;
            rd_addr_q      <= '0;
            issue_done_q   <= 1'b0;
        end else begin
            output_valid_q <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (wait_cnt_q == WCW'(WAIT_CYCLES - 1)) begin
                        state_q      <= S_COPY;
                        mode_q       <= cmd_q;
                        r_addr_q     <= '0;
                        rd_pend_q    <= 1'b0;
                        issue_done_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                S_COPY: begin
                    // Stage 2: the read issued last cycle has returned.
                    if (rd_pend_q) begin
                        output_valid_q <= 1'b1;
                        o_addr_q       <= rd_addr_q;
                        data_out_q     <= data_in;
                    end
                    // Stage 1: issue the next sequential read.
                    if (!issue_done_q) begin
                        rd_pend_q <= 1'b1;
                        rd_addr_q <= r_addr_q;
                        if (r_addr_q == LAST_ADDR) issue_done_q <= 1'b1;
                        else                       r_addr_q     <= r_addr_q + ADDR_WIDTH'(1);
                    end else begin
                        rd_pend_q <= 1'b0;
                    end
                    // Leave only once the last write is on the outputs, so the
                    // strobe never appears in the following state.
                    if (output_valid_q && o_addr_q == LAST_ADDR) begin
                        if (mode_q == 2'b01) begin
                            state_q     <= S_DONE;
                            all_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_CHECK;
                            x_q     <= '0;
                            y_q     <= YW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    r_addr_q <= rd_a[0];
                    fc_q     <= '0;
                    state_q  <= S_FETCH;
                end
                S_FETCH: begin
                    if (fc_q == n_rd) begin
                        output_valid_q <= 1'b1;
                        o_addr_q       <= cur_a;
                        data_out_q     <= res_d;
                        state_q        <= S_WRITE;
                    end else begin
                        if (fc_q + 3'd1 < n_rd) r_addr_q <= rd_a[fc_q + 3'd1];
                        fc_q <= fc_q + 3'd1;
                    end
                end
                S_WRITE: begin
                    if (x_q == X_LAST) begin
                        if (y_q == Y_LAST) begin
                            state_q     <= S_DONE;
                            all_ready_q <= 1'b1;
                        end else begin
                            x_q     <= '0;
                            y_q     <= y_q + YW'(2);
                            state_q <= S_CHECK;
                        end
                    end else begin
                        x_q     <= x_q + XW'(1);
                        state_q <= S_CHECK;
                    end
                end
                S_DONE: begin
                    if (cmd_q != mode_q) begin
                        state_q      <= S_COPY;
                        all_ready_q  <= 1'b0;
                        mode_q       <= cmd_q;
                        r_addr_q     <= '0;
                        rd_pend_q    <= 1'b0;
                        issue_done_q <= 1'b0;
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign r_addr       = r_addr_q;
    assign o_addr       = o_addr_q;
    assign data_out     = data_out_q;
    assign output_valid = output_valid_q;
    assign all_ready    = all_ready_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ela_deinterlace_engine.sv
`timescale 1ns/1ps
module tb_ela_deinterlace_engine;

    localparam int CW   = 4;
    localparam int NC   = 3;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 19;
    localparam int WC   = 4;
    localparam int DW   = CW * NC;
    localparam int NPIX = W * H;
    localparam int IW   = $clog2(NPIX);

    // ------------------------------------------------------ clock and reset
    logic          clk_p = 1'b0;
    logic          rst   = 1'b1;
    logic [1:0]    cmd   = 2'b00;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          output_valid;
    logic          all_ready;
    logic [2:0]    dbg_state;

    always #5 clk_p = ~clk_p;

    ela_deinterlace_engine #(
        .CH_WIDTH   (CW),
        .NUM_CH     (NC),
        .IMG_W      (W),
        .IMG_H      (H),
        .ADDR_WIDTH (AW),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk_p       (clk_p),
        .rst         (rst),
        .cmd         (cmd),
        .r_addr      (r_addr),
        .data_in     (data_in),
        .o_addr      (o_addr),
        .data_out    (data_out),
        .output_valid(output_valid),
        .all_ready   (all_ready),
        .dbg_state_o (dbg_state)
    );

    // -------------------------------------------- source / destination model
    logic [DW-1:0] src     [NPIX];
    logic [DW-1:0] dst     [NPIX];
    logic [DW-1:0] exp_img [NPIX];
    int            wr_cnt  = 0;
    int            oob_cnt = 0;
    int            tests_run = 0;
    int            fail_cnt  = 0;

    // One-cycle read latency source memory.
    always @(posedge clk_p) begin
        if (int'(r_addr) < NPIX) data_in <= src[r_addr[IW-1:0]];
        else                     data_in <= '0;
    end

    // Destination memory: record every strobed write.
    always @(negedge clk_p) begin
        if (!rst && output_valid) begin
            wr_cnt++;
            if (int'(o_addr) < NPIX) dst[o_addr[IW-1:0]] = data_out;
            else                     oob_cnt++;
        end
    end

    // ----------------------------------------------------------- scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic int chan(input logic [DW-1:0] p, input int c);
        return (int'(p) >> (c * CW)) & ((1 << CW) - 1);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [DW-1:0] ref_pixel(input int mode, input int x, input int y);
        logic [DW-1:0] r;
        int a, b, c, d, e, f, d1, d2, d3, v;
        r = '0;
        for (int ch = 0; ch < NC; ch++) begin
            b = chan(src[(y-1)*W + x], ch);
            e = chan(src[(y+1)*W + x], ch);
            if (mode == 2) begin
                v = b;
            end else if (mode == 3 || x == 0 || x == W-1) begin
                v = (b + e) / 2;
            end else begin
                a  = chan(src[(y-1)*W + x-1], ch);
                c  = chan(src[(y-1)*W + x+1], ch);
                d  = chan(src[(y+1)*W + x-1], ch);
                f  = chan(src[(y+1)*W + x+1], ch);
                d1 = iabs(a - f);
                d2 = iabs(b - e);
                d3 = iabs(c - d);
                if (d2 <= d1 && d2 <= d3) v = (b + e) / 2;
                else if (d1 <= d3)        v = (a + f) / 2;
                else                      v = (c + d) / 2;
            end
            r[ch*CW +: CW] = v[CW-1:0];
        end
        return r;
    endfunction

    task automatic build_expected(input int mode);
        for (int i = 0; i < NPIX; i++) exp_img[i] = src[i];
        if (mode != 1)
            for (int y = 1; y + 1 < H; y += 2)
                for (int x = 0; x < W; x++)
                    exp_img[y*W + x] = ref_pixel(mode, x, y);
    endtask

    function automatic int exp_writes(input int mode);
        return (mode == 1) ? NPIX : NPIX + W * ((H - 1) / 2);
    endfunction

    // -------------------------------------------------------- driver tasks
    task automatic clear_dst();
        for (int i = 0; i < NPIX; i++) dst[i] = 'x;
        wr_cnt  = 0;
        oob_cnt = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) src[i] = DW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_r_addr"},   r_addr,       0);
        check({tag, "_o_addr"},   o_addr,       0);
        check({tag, "_data_out"}, data_out,     0);
        check({tag, "_valid"},    output_valid, 0);
        check({tag, "_ready"},    all_ready,    0);
        check({tag, "_state"},    dbg_state,    0);
    endtask

    task automatic start_from_reset(input int mode, input bit chk);
        @(negedge clk_p);
        rst = 1'b1;
        cmd = mode[1:0];
        repeat (2) @(negedge clk_p);
        if (chk) check_reset_outputs("reset");
        clear_dst();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!all_ready && n < 2000) begin
            @(negedge clk_p);
            n++;
        end
        check({tag, "_done"}, all_ready, 1);
    endtask

    // Wait for completion, idle a while, then compare the whole image.
    task automatic finish_pass(input string tag, input int mode);
        int bad = 0;
        wait_done(tag);
        repeat (10) @(negedge clk_p);
        check({tag, "_ready_hold"}, all_ready, 1);
        check({tag, "_writes"}, wr_cnt, exp_writes(mode));
        check({tag, "_oob"}, oob_cnt, 0);
        build_expected(mode);
        for (int i = 0; i < NPIX; i++) if (dst[i] !== exp_img[i]) bad++;
        check({tag, "_img_bad_px"}, bad, 0);
        for (int i = 0; i < NPIX; i++)
            if (dst[i] !== exp_img[i])
                check($sformatf("%s_px%0d", tag, i), dst[i], exp_img[i]);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int n;
        int hi;

        // Copy pass on a ramp image.
        for (int i = 0; i < NPIX; i++) src[i] = {i[3:0], i[3:0], i[3:0]};
        start_from_reset(1, 1'b1);
        finish_pass("copy", 1);
        check("copy_px7", dst[7], 12'h777);

        // ELA tie: all three differences equal, vertical pair chosen.
        fill_random();
        for (int x = 0; x < W; x++) begin
            src[x]       = 12'h000;
            src[2*W + x] = 12'hFFF;
        end
        start_from_reset(0, 1'b0);
        finish_pass("ela_tie", 0);
        check("ela_tie_px11", dst[5], 12'h777);

        // ELA with the a/f diagonal smallest.
        fill_random();
        src[0]  = 12'h333;
        src[1]  = 12'hFFF;
        src[2]  = 12'h999;
        src[8]  = 12'h111;
        src[9]  = 12'h000;
        src[10] = 12'h555;
        start_from_reset(0, 1'b0);
        finish_pass("ela_diag", 0);
        check("ela_diag_px11", dst[5], 12'h444);

        // Channels differ: one channel is an edge, one is flat.
        fill_random();
        for (int x = 0; x < W; x++) begin
            src[x]       = 12'h053;
            src[2*W + x] = 12'hF57;
        end
        start_from_reset(0, 1'b0);
        finish_pass("ela_chan", 0);
        check("ela_chan_edge_px10", dst[4],  12'h755);
        check("ela_chan_px11",      dst[5],  12'h755);
        check("ela_chan_row3",      dst[13], src[13]);

        // Random images in each processing mode.
        for (int k = 0; k < 3; k++) begin
            fill_random();
            start_from_reset(2, 1'b0);
            finish_pass($sformatf("dbl%0d", k), 2);
            fill_random();
            start_from_reset(3, 1'b0);
            finish_pass($sformatf("vavg%0d", k), 3);
            fill_random();
            start_from_reset(0, 1'b0);
            finish_pass($sformatf("rnd_ela%0d", k), 0);
        end

        // Mode switch from DONE: full pass repeats with vertical averaging.
        clear_dst();
        cmd = 2'b11;
        n = 0;
        while (all_ready && n < 20) begin
            @(negedge clk_p);
            n++;
        end
        check("switch_ready_fell", all_ready, 0);
        finish_pass("switch", 3);

        // Reset in the middle of FETCH.
        fill_random();
        start_from_reset(0, 1'b0);
        n = 0;
        while (dbg_state != 3'd3 && n < 200) begin
            @(negedge clk_p);
            n++;
        end
        check("midrst_reached_fetch", dbg_state, 3);
        rst = 1'b1;
        @(negedge clk_p);
        check_reset_outputs("midrst");
        clear_dst();
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < WC; i++) begin
            @(negedge clk_p);
            if (output_valid !== 1'b0 || all_ready !== 1'b0) hi++;
        end
        check("midrst_quiet", hi, 0);
        finish_pass("midrst", 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ela_deinterlace_engine.md
ELA_DEINTERLACE_ENGINE -- requirements
Module: ela_deinterlace_engine

Interface
REQ-001 SHALL have parameter CH_WIDTH, default 4, bits per colour channel.
REQ-002 SHALL have parameter NUM_CH, default 3, channels per pixel; DATA_WIDTH = CH_WIDTH*NUM_CH (default 12).
REQ-003 SHALL have parameters IMG_W, default 400, and IMG_H, default 300, image size in pixels; IMG_W >= 3, IMG_H >= 3.
REQ-004 SHALL have parameter ADDR_WIDTH, default 19, with 2^ADDR_WIDTH >= IMG_W*IMG_H.
REQ-005 SHALL have parameter WAIT_CYCLES, default 1024, power-up settle time.
REQ-006 clk_p  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 cmd  input  2  mode: 00 ELA, 01 copy, 10 line-double, 11 vertical average.
REQ-009 r_addr  output  ADDR_WIDTH  source-memory read address.
REQ-010 data_in  input  DATA_WIDTH  source data; 1-cycle read latency after r_addr.
REQ-011 o_addr  output  ADDR_WIDTH  destination write address.
REQ-012 data_out  output  DATA_WIDTH  destination write data.
REQ-013 output_valid  output  1  destination write strobe, one write per high cycle.
REQ-014 all_ready  output  1  high while the current pass is complete.

Function
REQ-015 FSM states: WAIT, COPY, CHECK, FETCH, WRITE, DONE; WAIT -> COPY after WAIT_CYCLES cycles from reset.
REQ-016 On entering COPY, cmd SHALL be latched into mode_q; cmd changes during a pass are ignored.
REQ-017 COPY SHALL read all IMG_W*IMG_H pixels in address order and write each unchanged to the same o_addr, one pixel per cycle after 1-cycle pipeline fill.
REQ-018 After the last copy write: mode_q=01 -> DONE; otherwise -> CHECK at y=1, x=0.
REQ-019 Only odd rows y=1,3,..., y<=IMG_H-2 SHALL be rewritten; rows with y+1 >= IMG_H are left as copied.
REQ-020 ELA interior pixel (0<x<IMG_W-1): fetch a=(y-1,x-1), b=(y-1,x), c=(y-1,x+1), d=(y+1,x-1), e=(y+1,x), f=(y+1,x+1); 6 reads, 7 FETCH cycles.
REQ-021 ELA per channel independently: d1=|a-f|, d2=|b-e|, d3=|c-d|; choose d2 if d2<=d1 and d2<=d3, else d1 if d1<=d3, else d3; result=(pair sum)>>1 using CH_WIDTH+1-bit sum.
REQ-022 ELA edge pixel (x=0 or x=IMG_W-1) and mode 11 at any x: per channel (b+e)>>1; 2 reads, 3 FETCH cycles.
REQ-023 Mode 10: each channel = b; 1 read, 2 FETCH cycles.
REQ-024 WRITE SHALL assert output_valid for exactly one cycle with o_addr=y*IMG_W+x and the computed data_out.
REQ-025 After WRITE: x=IMG_W-1 -> x=0, y+=2; last processed pixel -> DONE; else -> CHECK.
REQ-026 all_ready SHALL rise on the cycle DONE is entered and stay high until a new pass starts.
REQ-027 In DONE, a registered cmd differing from mode_q SHALL clear all_ready and restart at COPY (no WAIT) next cycle.
REQ-028 output_valid SHALL be low in WAIT, CHECK, FETCH and DONE.
REQ-029 Address arithmetic SHALL use ADDR_WIDTH bits with no wrap; x,y counters sized by clog2 of IMG_W, IMG_H.

Reset
REQ-030 On rst high at any clock edge, state=WAIT, settle counter=0, r_addr=0, o_addr=0, data_out=0, output_valid=0, all_ready=0, mode_q=00.
REQ-031 rst mid-pass SHALL abort with no further writes and require full WAIT_CYCLES before the next pass.

Verification (IMG_W=4, IMG_H=4, CH_WIDTH=4, NUM_CH=3, WAIT_CYCLES=4)
REQ-032 cmd=01, ramp image pix[i]=i replicated in 3 channels -> 16 writes, data_out=source, all_ready=1, no further writes.
REQ-033 cmd=00, row0=0x000, row2=0xFFF, pixel(1,1) -> d2=15 vs d1,d3=15 tie, d2 chosen, data_out=0x777.
REQ-034 cmd=00, pixel(1,1) with a=0x3,f=0x5,b=0xF,e=0x0,c=0x9,d=0x1 per channel -> d1=2 selected, data_out=0x444.
REQ-035 cmd=00, channels differ (R edge, G flat) -> per-channel independent results; edge x=0 uses (b+e)>>1; row 3 untouched.
REQ-036 Pass done with cmd=00, switch cmd to 11 -> all_ready falls, full COPY repeats, odd rows rewritten as vertical average, all_ready rises.
REQ-037 rst asserted during FETCH -> output_valid=0 next cycle, all_ready=0, no writes for WAIT_CYCLES cycles.
